// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 receiver state encoding, frame size and shared scan codes.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: synchronizes both PS/2 pins and debounces the clock into a one-cycle fall strobe.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic PS2_CLK,
  input  logic PS2_DAT,
  output logic fall,
  output logic dat
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_s, dat_s;
  logic filt;
  logic [CW-1:0] cnt;
  assign dat = dat_s[1];
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt  <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DAT};
      fall  <= 1'b0;
      // the filtered level only moves after FILTER_LEN agreeing samples
      if (clk_s[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        cnt  <= '0;
        fall <= filt;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receive-only PS/2 frame deserializer with parity, stop-bit and timeout checking.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       frame_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_t state;
  logic fall, dat, par;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tcnt;
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .fall(fall),
    .dat(dat)
  );
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state            <= IDLE;
      shreg            <= '0;
      bit_cnt          <= '0;
      par              <= 1'b0;
      tcnt             <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      frame_error      <= 1'b0;
      tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
      // a fall in the timeout cycle is processed, so it takes precedence
      if (fall) begin
        case (state)
          IDLE: if (!dat) begin
            state   <= DATA;
            bit_cnt <= '0;
            shreg   <= '0;
          end
          DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat) frame_error <= 1'b1;
            else if (!odd_ok(shreg, par)) parity_error <= 1'b1;
            else begin
              received_data    <= shreg;
              received_data_en <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        frame_error <= 1'b1;
      end
    end
endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Receive-only PS/2 deserializer for the car game's keyboard path. It samples the raw `PS2_CLK`/`PS2_DAT` pins and recovers 11-bit device-to-host frames (start, 8 data, odd parity, stop). Each valid byte is delivered as `received_data` with a one-cycle `received_data_en` strobe, which feeds the scan-code decoder directly. Malformed or stalled frames are dropped and flagged.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive `CLOCK_50` cycles a synchronized `PS2_CLK` level must hold before the filtered clock follows it.
- `TIMEOUT_CYCLES`, 50000: maximum cycles between filtered falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `PS2_CLK`  in  1  raw PS/2 clock pin, asynchronous to `CLOCK_50`.
- `PS2_DAT`  in  1  raw PS/2 data pin, asynchronous.
- `received_data`  out  8  last valid byte; holds its value between strobes.
- `received_data_en`  out  1  one-cycle strobe; `received_data` is valid in the same cycle.
- `parity_error`  out  1  one-cycle pulse: frame complete, parity bad.
- `frame_error`  out  1  one-cycle pulse: bad stop bit or inter-edge timeout.

## Operation
- Input conditioning:
  - Both pins pass through 2-flop synchronizers, reset to 1.
  - The synchronized clock feeds a glitch filter: a counter of 0..FILTER_LEN-1 that restarts on any disagreement with the filtered level. The filtered clock resets to 1.
  - A falling edge of the filtered clock (`fall`) is the only event that samples data. Data is sampled from synchronized `PS2_DAT` in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, go to DATA, clear the bit count and shift register. On `fall` with data 1, stay in IDLE with no error (line noise).
  - DATA: on each `fall`, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, return to IDLE and resolve the frame in priority order:
    - stop bit = 0: `frame_error`.
    - stop bit = 1 and the XOR of the 8 data bits plus parity is 0 (not odd): `parity_error`.
    - otherwise: load `received_data` and pulse `received_data_en`.
  - At most one of the three outputs pulses per frame.
- Timeout:
  - A counter clears on every `fall` and counts while the FSM is not in IDLE.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, the partial frame is discarded, and `frame_error` pulses once.
  - If `fall` arrives in the same cycle as the timeout, `fall` wins: it is processed and the counter clears.
- Host-to-device transmission is not supported. The pins are inputs only.

## Timing
- Reset values: `received_data`=8'h00, `received_data_en`=0, `parity_error`=0, `frame_error`=0, FSM=IDLE, counters 0.
- Reset mid-frame discards the partial frame with no pulse. The next frame is received normally once both pins have been stable for sync + filter depth.
- Latency from the stop-bit falling edge on the pin to `received_data_en` = 2 (sync) + FILTER_LEN (filter) + 1 (FSM register) = 11 cycles at default.
- Clock pulses shorter than FILTER_LEN cycles, low or high, are ignored entirely.
- Consumer handshake: there is no backpressure. The consumer must capture on the strobe. `received_data` is stable until the next valid frame.
- Minimum strobe spacing is about 1 frame (≥ 11 × 60 µs at PS/2 rates). Back-to-back bytes (E0, F0, code) each produce a separate strobe.

## Structure
- `ps2_pkg`: FSM state encoding, `PS2_FRAME_BITS`=11, and the scan-code constants shared with the decoder (8'h5A, 8'h6B, 8'h74, 8'hE0, 8'hF0).
- Sub-module `ps2_sync_filter`: 2-flop synchronizers for both pins, clock glitch filter, and the `fall` strobe plus synchronized data output. It is instantiated once.
- Top level holds the FSM, shift register, bit counter, and timeout counter.

## Test plan
- Valid 0x5A frame (bits 0,0,1,0,1,1,0,1,0, parity 1, stop 1) at 15 kHz → exactly one `received_data_en`, `received_data`=8'h5A, 11 cycles after the stop-bit edge.
- Sequence E0, F0, 6B (parity 0, 1, 0) → three strobes carrying 8'hE0, 8'hF0, 8'h6B in order; no error pulses.
- 0x5A sent with parity 0 → one `parity_error` pulse; no strobe; `received_data` keeps its prior value.
- 0x74 sent with stop bit 0 → one `frame_error`; no strobe. A following valid 0x74 (parity 1) → strobe with 8'h74.
- Clock stops after 4 data bits → `frame_error` exactly TIMEOUT_CYCLES after the last `fall`; FSM returns to IDLE. A following valid 0x5A is received.
- 3-cycle low glitch on `PS2_CLK` in IDLE and mid-frame → no state change and correct byte received. Reset asserted mid-frame → no pulses, all outputs at reset values.
